// File: rtl/pixel_buf_pkg.sv
// Shared definitions for the convolution-layer pixel buffer: loader state
// encodings and helpers that place the col/row/ch fields inside an address.
package pixel_buf_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A field always occupies at least one bit, even for a dimension of 1.
  function automatic int field_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int row_lsb(input int cols);
    return field_w(cols);
  endfunction

  function automatic int ch_lsb(input int rows, input int cols);
    return field_w(cols) + field_w(rows);
  endfunction

endpackage

// File: rtl/pixel_load_ctrl.sv
// Streaming frame loader: walks the frame in channel-major raster order and
// issues one storage write per accepted valid/ready handshake.
module pixel_load_ctrl
  import pixel_buf_pkg::*;
#(
  parameter int CH   = 3,
  parameter int ROWS = 32,
  parameter int COLS = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clr,
  input  logic                      i_load_start,
  input  logic                      i_s_valid,
  output logic                      o_s_ready,
  output logic                      o_load_done,
  output logic                      o_frame_ready,
  output logic                      o_idle,
  output logic                      o_st_we,
  output logic [field_w(ROWS)-1:0]  o_st_row,
  output logic [field_w(COLS)-1:0]  o_st_col,
  output logic [field_w(CH)-1:0]    o_st_ch
);

  localparam int COL_W = field_w(COLS);
  localparam int ROW_W = field_w(ROWS);
  localparam int CH_W  = field_w(CH);

  logic [1:0]       r_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [CH_W-1:0]  r_ch;
  logic             r_frame_ready;

  logic w_hs;
  logic w_col_end;
  logic w_row_end;
  logic w_last;

  assign o_s_ready     = (r_state == ST_LOAD);
  assign o_load_done   = (r_state == ST_DONE);
  assign o_idle        = (r_state == ST_IDLE);
  assign o_frame_ready = r_frame_ready;
  assign w_hs          = o_s_ready && i_s_valid;
  assign w_col_end     = (int'(r_col) == COLS - 1);
  assign w_row_end     = (int'(r_row) == ROWS - 1);
  assign w_last        = w_col_end && w_row_end && (int'(r_ch) == CH - 1);

  assign o_st_we  = w_hs;
  assign o_st_row = r_row;
  assign o_st_col = r_col;
  assign o_st_ch  = r_ch;

  // A restart inside LOAD only rewinds the counters; samples already stored stay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_col         <= '0;
      r_row         <= '0;
      r_ch          <= '0;
      r_frame_ready <= 1'b0;
    end else if (i_clr) begin
      r_state       <= ST_IDLE;
      r_col         <= '0;
      r_row         <= '0;
      r_ch          <= '0;
      r_frame_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_load_start) begin
            r_col         <= '0;
            r_row         <= '0;
            r_ch          <= '0;
            r_frame_ready <= 1'b0;
            r_state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (i_load_start) begin
            r_col <= '0;
            r_row <= '0;
            r_ch  <= '0;
          end else if (w_hs) begin
            if (w_last) begin
              r_col   <= '0;
              r_row   <= '0;
              r_ch    <= '0;
              r_state <= ST_DONE;
            end else if (w_col_end) begin
              r_col <= '0;
              if (w_row_end) begin
                r_row <= '0;
                r_ch  <= r_ch + 1'b1;
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_frame_ready <= 1'b1;
          r_state       <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/local_mem_pixel_buf.sv
// On-chip ROWS x COLS x CH pixel buffer feeding the PE array: direct
// single-channel writes or a streamed frame load, whole-pixel registered reads.
module local_mem_pixel_buf
  import pixel_buf_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CH     = 3,
  parameter int ROWS   = 32,
  parameter int COLS   = 32,
  parameter int ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_wr_en,
  input  logic [ADDR_W-1:0]    i_wr_addr,
  input  logic [DATA_W-1:0]    i_wr_data,
  input  logic                 i_rd_en,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  output logic [CH*DATA_W-1:0] o_rd_data,
  output logic                 o_rd_valid,
  input  logic                 i_load_start,
  input  logic                 i_s_valid,
  input  logic [DATA_W-1:0]    i_s_data,
  output logic                 o_s_ready,
  output logic                 o_load_done,
  output logic                 o_frame_ready,
  output logic                 o_wr_err
);

  localparam int COL_W   = field_w(COLS);
  localparam int ROW_W   = field_w(ROWS);
  localparam int CH_W    = field_w(CH);
  localparam int ROW_LSB = row_lsb(COLS);
  localparam int CH_LSB  = ch_lsb(ROWS, COLS);

  logic [DATA_W-1:0]    r_mem [ROWS][COLS][CH];
  logic [CH*DATA_W-1:0] r_rd_data;
  logic                 r_rd_valid;
  logic                 r_wr_err;

  logic [COL_W-1:0]     w_wr_col, w_rd_col, w_st_col, w_we_col;
  logic [ROW_W-1:0]     w_wr_row, w_rd_row, w_st_row, w_we_row;
  logic [CH_W-1:0]      w_wr_ch, w_st_ch, w_we_ch;
  logic [DATA_W-1:0]    w_we_data;
  logic                 w_wr_in_range, w_rd_in_range;
  logic                 w_idle, w_st_we, w_dir_we, w_mem_we;
  logic [CH*DATA_W-1:0] w_rd_pixel;
  logic                 w_unused_addr;

  pixel_load_ctrl #(
    .CH   (CH),
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_load_ctrl (
    .clk           (clk),
    .rst           (rst),
    .i_clr         (i_clr),
    .i_load_start  (i_load_start),
    .i_s_valid     (i_s_valid),
    .o_s_ready     (o_s_ready),
    .o_load_done   (o_load_done),
    .o_frame_ready (o_frame_ready),
    .o_idle        (w_idle),
    .o_st_we       (w_st_we),
    .o_st_row      (w_st_row),
    .o_st_col      (w_st_col),
    .o_st_ch       (w_st_ch)
  );

  assign w_wr_col = i_wr_addr[0 +: COL_W];
  assign w_wr_row = i_wr_addr[ROW_LSB +: ROW_W];
  assign w_wr_ch  = i_wr_addr[CH_LSB +: CH_W];
  assign w_rd_col = i_rd_addr[0 +: COL_W];
  assign w_rd_row = i_rd_addr[ROW_LSB +: ROW_W];
  assign w_unused_addr = ^{i_wr_addr[ADDR_W-1:CH_LSB+CH_W], i_rd_addr[ADDR_W-1:ROW_LSB]};

  assign w_wr_in_range = (int'(w_wr_row) < ROWS) && (int'(w_wr_col) < COLS) &&
                         (int'(w_wr_ch) < CH);
  assign w_rd_in_range = (int'(w_rd_row) < ROWS) && (int'(w_rd_col) < COLS);

  // Direct writes are only honoured while the loader is idle, so the two
  // write sources never collide on the single storage port.
  assign w_dir_we  = i_wr_en && w_idle && w_wr_in_range;
  assign w_mem_we  = w_dir_we || w_st_we;
  assign w_we_row  = w_st_we ? w_st_row : w_wr_row;
  assign w_we_col  = w_st_we ? w_st_col : w_wr_col;
  assign w_we_ch   = w_st_we ? w_st_ch  : w_wr_ch;
  assign w_we_data = w_st_we ? i_s_data : i_wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          for (int k = 0; k < CH; k++)
            r_mem[r][c][k] <= '0;
    end else if (i_clr) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          for (int k = 0; k < CH; k++)
            r_mem[r][c][k] <= '0;
    end else if (w_mem_we) begin
      r_mem[w_we_row][w_we_col][w_we_ch] <= w_we_data;
    end
  end

  always_comb begin
    w_rd_pixel = '0;
    if (w_rd_in_range) begin
      for (int k = 0; k < CH; k++)
        w_rd_pixel[k*DATA_W +: DATA_W] = r_mem[w_rd_row][w_rd_col][k];
    end
  end

  // Sampling storage before this edge's write gives read-before-write ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_wr_err   <= 1'b0;
    end else if (i_clr) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      r_rd_data  <= i_rd_en ? w_rd_pixel : '0;
      r_wr_err   <= i_wr_en && !(w_idle && w_wr_in_range);
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_wr_err   = r_wr_err;

endmodule

// File: tb/tb_local_mem_pixel_buf.sv
// Self-checking bench for local_mem_pixel_buf: vector table, randomized
// direct traffic against an array model, and streamed-load corner sequences.
module tb_local_mem_pixel_buf;

  localparam int DATA_W = 16;
  localparam int CH     = 3;
  localparam int ROWS   = 32;
  localparam int COLS   = 32;
  localparam int ADDR_W = 16;
  localparam int TOTAL  = CH * ROWS * COLS;

  logic                 clk, rst, clr;
  logic                 wrEn, rdEn, loadStart, sValid;
  logic [ADDR_W-1:0]    wrAddr, rdAddr;
  logic [DATA_W-1:0]    wrData, sData;
  logic [CH*DATA_W-1:0] rdData;
  logic                 rdValid, sReady, loadDone, frameReady, wrErr;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] model [ROWS][COLS][CH];

  typedef struct {
    logic        wrEn;
    logic [15:0] wrAddr;
    logic [15:0] wrData;
    logic        rdEn;
    logic [15:0] rdAddr;
    logic [47:0] expData;
    logic        expValid;
    logic        expErr;
  } vec_t;

  vec_t vecTable [12];

  local_mem_pixel_buf #(
    .DATA_W (DATA_W),
    .CH     (CH),
    .ROWS   (ROWS),
    .COLS   (COLS),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_clr         (clr),
    .i_wr_en       (wrEn),
    .i_wr_addr     (wrAddr),
    .i_wr_data     (wrData),
    .i_rd_en       (rdEn),
    .i_rd_addr     (rdAddr),
    .o_rd_data     (rdData),
    .o_rd_valid    (rdValid),
    .i_load_start  (loadStart),
    .i_s_valid     (sValid),
    .i_s_data      (sData),
    .o_s_ready     (sReady),
    .o_load_done   (loadDone),
    .o_frame_ready (frameReady),
    .o_wr_err      (wrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pixAddr(input int ch, input int row, input int col);
    return 16'((ch << 10) | (row << 5) | col);
  endfunction

  // Stream sample k lands at channel k/(R*C), row (k/C)%R, col k%C.
  function automatic logic [47:0] streamPix(input int base, input int row, input int col);
    logic [47:0] p;
    for (int c = 0; c < CH; c++)
      p[c*DATA_W +: DATA_W] = 16'(base + c*ROWS*COLS + row*COLS + col);
    return p;
  endfunction

  function automatic vec_t mkVec(input logic we, input logic [15:0] wa, input logic [15:0] wd,
                                 input logic re, input logic [15:0] ra,
                                 input logic [47:0] ed, input logic ev, input logic ee);
    vec_t v;
    v.wrEn = we; v.wrAddr = wa; v.wrData = wd;
    v.rdEn = re; v.rdAddr = ra;
    v.expData = ed; v.expValid = ev; v.expErr = ee;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    wrEn   = v.wrEn;
    wrAddr = v.wrAddr;
    wrData = v.wrData;
    rdEn   = v.rdEn;
    rdAddr = v.rdAddr;
    @(negedge clk);
    wrEn = 1'b0;
    rdEn = 1'b0;
  endtask

  task automatic readPixel(input int row, input int col, output logic [47:0] d, output logic v);
    rdEn   = 1'b1;
    rdAddr = pixAddr(0, row, col);
    @(negedge clk);
    rdEn = 1'b0;
    d = rdData;
    v = rdValid;
  endtask

  task automatic pulseLoadStart();
    loadStart = 1'b1;
    @(negedge clk);
    loadStart = 1'b0;
  endtask

  initial begin
    logic [47:0] d;
    logic        v, hs, inject, injected;
    int          accepted, cyc, doneBad, frBad, cnt, seen;
    int          row, col, ch;
    logic [47:0] expPix;

    rst = 1'b1; clr = 1'b0; wrEn = 1'b0; rdEn = 1'b0; loadStart = 1'b0; sValid = 1'b0;
    wrAddr = '0; rdAddr = '0; wrData = '0; sData = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset outputs", {rdData, rdValid, sReady, loadDone, frameReady, wrErr}, 64'h0);

    // Put non-zero values on the outputs, then drop reset between edges.
    wrEn = 1'b1; wrAddr = pixAddr(0, 1, 1); wrData = 16'h7777;
    @(negedge clk);
    wrEn = 1'b0; rdEn = 1'b1; rdAddr = pixAddr(0, 1, 1); loadStart = 1'b1;
    @(negedge clk);
    rdEn = 1'b0; loadStart = 1'b0;
    checkOutput("pre-reset outputs", {rdValid, sReady, rdData}, {1'b1, 1'b1, 48'h7777});
    #2 rst = 1'b1;
    #1 checkOutput("async reset outputs", {rdData, rdValid, sReady, loadDone, frameReady, wrErr}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    readPixel(1, 1, d, v);
    checkOutput("storage cleared by reset", {v, d}, {1'b1, 48'h0});

    vecTable[0]  = mkVec(0, 16'h0000, 16'h0000, 1, 16'h0065, 48'h0, 1, 0);
    vecTable[1]  = mkVec(1, 16'h00E9, 16'h1111, 0, 16'h0000, 48'h0, 0, 0);
    vecTable[2]  = mkVec(1, 16'h04E9, 16'h2222, 0, 16'h0000, 48'h0, 0, 0);
    vecTable[3]  = mkVec(1, 16'h08E9, 16'h3333, 1, 16'h00E9, 48'h0000_2222_1111, 1, 0);
    vecTable[4]  = mkVec(0, 16'h0000, 16'h0000, 1, 16'h00E9, 48'h3333_2222_1111, 1, 0);
    vecTable[5]  = mkVec(1, 16'h0C00, 16'hDEAD, 0, 16'h0000, 48'h0, 0, 1);
    vecTable[6]  = mkVec(0, 16'h0000, 16'h0000, 1, 16'h0000, 48'h0, 1, 0);
    vecTable[7]  = mkVec(1, 16'h0000, 16'hABCD, 1, 16'h0000, 48'h0, 1, 0);
    vecTable[8]  = mkVec(0, 16'h0000, 16'h0000, 1, 16'h0000, 48'h0000_0000_ABCD, 1, 0);
    vecTable[9]  = mkVec(1, 16'hF0E9, 16'h5555, 0, 16'h0000, 48'h0, 0, 0);
    vecTable[10] = mkVec(0, 16'h0000, 16'h0000, 1, 16'hFCE9, 48'h3333_2222_5555, 1, 0);
    vecTable[11] = mkVec(0, 16'h0000, 16'h0000, 0, 16'h00E9, 48'h0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecTable[i]);
      checkOutput($sformatf("vec%0d rd_data", i), rdData, vecTable[i].expData);
      checkOutput($sformatf("vec%0d rd_valid", i), rdValid, vecTable[i].expValid);
      checkOutput($sformatf("vec%0d wr_err", i), wrErr, vecTable[i].expErr);
    end

    clr = 1'b1; rdEn = 1'b1; rdAddr = 16'h00E9;
    @(negedge clk);
    clr = 1'b0; rdEn = 1'b0;
    checkOutput("clr outputs", {rdData, rdValid, sReady, loadDone, frameReady, wrErr}, 64'h0);

    // Randomized direct traffic against the array model.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int k = 0; k < CH; k++)
          model[r][c][k] = '0;
    for (int i = 0; i < 300; i++) begin
      vec_t rv;
      int rr, rc;
      ch  = $urandom_range(0, 3);
      row = $urandom_range(0, ROWS-1);
      col = $urandom_range(0, COLS-1);
      rr  = $urandom_range(0, 1) ? row : $urandom_range(0, ROWS-1);
      rc  = $urandom_range(0, 1) ? col : $urandom_range(0, COLS-1);
      rv.wrEn   = 1'($urandom_range(0, 1));
      rv.wrAddr = pixAddr(ch, row, col) | 16'($urandom_range(0, 15) << 12);
      rv.wrData = 16'($urandom);
      rv.rdEn   = 1'($urandom_range(0, 1));
      rv.rdAddr = pixAddr($urandom_range(0, 3), rr, rc) | 16'($urandom_range(0, 15) << 12);
      expPix = '0;
      if (rv.rdEn)
        for (int c = 0; c < CH; c++) expPix[c*DATA_W +: DATA_W] = model[rr][rc][c];
      rv.expData  = expPix;
      rv.expValid = rv.rdEn;
      rv.expErr   = rv.wrEn && (ch >= CH);
      applyStimulus(rv);
      checkOutput($sformatf("rand%0d read", i), {rdValid, rdData}, {rv.expValid, rv.expData});
      checkOutput($sformatf("rand%0d wr_err", i), wrErr, rv.expErr);
      if (rv.wrEn && ch < CH) model[row][col][ch] = rv.wrData;
    end

    // Full streamed load with a throttled source and a blocked direct write.
    pulseLoadStart();
    accepted = 0; cyc = 0; doneBad = 0; frBad = 0; injected = 1'b0;
    while (accepted < TOTAL && cyc < 20000) begin
      sValid = (cyc % 2 == 1);
      sData  = 16'(accepted);
      hs     = sValid && sReady;
      inject = (accepted == 2000) && !injected;
      if (inject) begin
        wrEn = 1'b1; wrAddr = 16'h0000; wrData = 16'hDEAD; injected = 1'b1;
      end
      @(negedge clk);
      cyc++;
      wrEn = 1'b0;
      if (hs) accepted++;
      if (inject) checkOutput("wr_err during load", wrErr, 1'b1);
      if (loadDone !== (hs && accepted == TOTAL)) doneBad++;
      if (frameReady !== 1'b0 && accepted < TOTAL) frBad++;
    end
    sValid = 1'b0;
    checkOutput("load handshakes", accepted, TOTAL);
    checkOutput("load_done timing", doneBad, 0);
    checkOutput("frame_ready low during load", frBad, 0);
    @(negedge clk);
    checkOutput("post-load status", {loadDone, frameReady, sReady}, 3'b010);
    readPixel(31, 31, d, v);
    checkOutput("pixel 31,31", {v, d}, {1'b1, 48'h0BFF_07FF_03FF});
    readPixel(0, 0, d, v);
    checkOutput("pixel 0,0 untouched by dropped write", d, 48'h0800_0400_0000);
    for (int i = 0; i < 30; i++) begin
      row = $urandom_range(0, ROWS-1);
      col = $urandom_range(0, COLS-1);
      readPixel(row, col, d, v);
      checkOutput($sformatf("loaded pixel %0d,%0d", row, col), d, streamPix(0, row, col));
    end
    wrEn = 1'b1; wrAddr = pixAddr(1, 4, 4); wrData = 16'h1234;
    @(negedge clk);
    wrEn = 1'b0;
    checkOutput("frame_ready after direct write", {frameReady, wrErr}, 2'b10);

    // Abort with clr after 100 samples.
    pulseLoadStart();
    checkOutput("frame_ready cleared by load_start", frameReady, 1'b0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      sValid = 1'b1; sData = 16'(16'hA000 + i);
      hs = sReady;
      @(negedge clk);
      if (hs) cnt++;
    end
    checkOutput("abort handshakes", cnt, 100);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("clr abort status", {sReady, frameReady, loadDone}, 3'b000);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (sReady || loadDone) seen++;
    end
    sValid = 1'b0;
    checkOutput("no load_done after abort", seen, 0);
    readPixel(0, 5, d, v);
    checkOutput("pixel 0,5 after abort", {v, d}, {1'b1, 48'h0});
    readPixel(31, 31, d, v);
    checkOutput("pixel 31,31 after abort", d, 48'h0);

    // Restart mid-load: the counters rewind and a full frame is needed again.
    pulseLoadStart();
    for (int i = 0; i < 50; i++) begin
      sValid = 1'b1; sData = 16'(16'hF000 + i);
      @(negedge clk);
    end
    sValid = 1'b0;
    pulseLoadStart();
    cnt = 0; seen = 0; cyc = 0;
    while (seen == 0 && cyc < 5000) begin
      sValid = 1'b1; sData = 16'(16'h4000 + cnt);
      hs = sReady;
      @(negedge clk);
      cyc++;
      if (hs) cnt++;
      if (loadDone) seen = 1;
    end
    sValid = 1'b0;
    checkOutput("restart load_done seen", seen, 1);
    checkOutput("restart handshakes", cnt, TOTAL);
    @(negedge clk);
    readPixel(0, 0, d, v);
    checkOutput("restart pixel 0,0", d, streamPix(16'h4000, 0, 0));
    readPixel(0, 1, d, v);
    checkOutput("restart pixel 0,1", d, 48'h4801_4401_4001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/local_mem_pixel_buf.md
Name: local_mem_pixel_buf

Overview:
- Parametrised on-chip pixel buffer for the convolution layer: a ROWS x COLS array of pixels, each pixel holding CH channels of DATA_W bits.
- Loaded in one of two ways:
  - random-access single-channel writes;
  - a streaming valid/ready loader FSM that fills the whole frame in channel-major raster order.
- Reads return all channels of one pixel, one cycle after the request, with a valid strobe.
- Sits between the DMA/bus wrapper and the PE array's input feeder.

Parameters:
- DATA_W, 16, bits per channel sample
- CH, 3, channels per pixel (1..4)
- ROWS, 32, frame height in pixels
- COLS, 32, frame width in pixels
- ADDR_W, 16, width of wr_addr/rd_addr buses

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear of all storage and status
- wr_en  in  1  single-channel write strobe
- wr_addr  in  ADDR_W  {.., ch, row, col} packed from LSB: col[COL_W-1:0], row next ROW_W bits, ch next CH_W bits
- wr_data  in  DATA_W  write sample
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  {.., row, col}, same col/row packing; ch field ignored
- rd_data  out  CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- rd_valid  out  1  rd_data valid, one cycle after rd_en
- load_start  in  1  pulse: begin streaming frame load
- s_valid  in  1  stream sample valid
- s_data  in  DATA_W  stream sample
- s_ready  out  1  loader accepting samples
- load_done  out  1  one-cycle pulse after last stream sample written
- frame_ready  out  1  level: a complete streamed frame is resident
- wr_err  out  1  one-cycle pulse: a direct write was dropped

Behaviour:
- Widths:
  - COL_W = max(1, clog2(COLS)); ROW_W = max(1, clog2(ROWS)); CH_W = max(1, clog2(CH)).
  - Bits of either address bus above the used fields are ignored.
- Reset (async) and clr (sync, same cycle edge):
  - All storage = 0; FSM = IDLE.
  - rd_data = 0, rd_valid = 0, s_ready = 0, load_done = 0, frame_ready = 0, wr_err = 0.
  - clr has priority over every other input in that cycle.
- Direct write:
  - On a clock edge with wr_en = 1, FSM in IDLE, row < ROWS, col < COLS and ch < CH, mem[row][col][ch] <= wr_data.
  - Other channels of that pixel are unchanged.
  - Out-of-range address, or wr_en while FSM is LOAD: write dropped and wr_err pulses next cycle.
  - A direct write does not change frame_ready.
- Read:
  - rd_en at edge N -> rd_data/rd_valid registered at edge N+1.
  - Out-of-range row/col: rd_data = 0 with rd_valid = 1.
  - Without rd_en: rd_valid = 0 and rd_data = 0.
  - Read and write to the same pixel in the same cycle: read returns the pre-write value (read-before-write).
  - Reads are allowed during LOAD.
- Loader FSM, states IDLE, LOAD, DONE:
  - IDLE: s_ready = 0. On load_start, clear the counters (col_cnt, row_cnt, ch_cnt), set frame_ready = 0, go to LOAD.
  - LOAD: s_ready = 1. Each cycle with s_valid & s_ready writes s_data to mem[row_cnt][col_cnt][ch_cnt] and advances the counters:
    - col_cnt increments; at COLS-1 it wraps to 0 and row_cnt increments;
    - row_cnt at ROWS-1 wraps to 0 and ch_cnt increments;
    - the final sample is ch = CH-1, row = ROWS-1, col = COLS-1; its write goes to DONE.
  - Cycles without s_valid hold all counters.
  - load_start while in LOAD restarts the counters; already-written data is kept.
  - DONE: load_done = 1 for exactly this one cycle, frame_ready <= 1, s_ready = 0, go to IDLE.
  - Total accepted samples = CH*ROWS*COLS (3072 at defaults).
- Reset or clr mid-LOAD: abort, storage zeroed, no load_done.

Decomposition:
- Package pixel_buf_pkg: loader state enum (IDLE/LOAD/DONE) and the address-field offset helper functions (col/row/ch slice positions from the parameters).
- One sub-module, pixel_load_ctrl: loader FSM plus raster counters. It outputs the stream write strobe and address, s_ready and load_done.
- Storage, the write arbitration and the read register stay in the top module.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately; rd_en to (3,5) after release -> rd_valid = 1, rd_data = 48'h0.
- Direct writes:
  - write ch0 = 16'h1111, ch1 = 16'h2222, ch2 = 16'h3333 to row 7, col 9 (wr_addr = 16'h00E9, 16'h04E9, 16'h08E9);
  - rd_addr = 16'h00E9 -> next cycle rd_data = 48'h3333_2222_1111, rd_valid = 1.
- Errors:
  - wr_addr ch field = 3 (16'h0C00) -> wr_err pulse, memory unchanged.
  - Same-cycle read/write of (0,0), old 0, new 16'hABCD -> read returns 0; next read returns 16'hABCD in ch0.
- Streamed load:
  - load_start, then 3072 samples with s_data = index, s_valid toggling every other cycle;
  - exactly 3072 handshakes, load_done one cycle after the last, frame_ready = 1;
  - pixel (31,31) reads 48'h0BFF_07FF_03FF;
  - wr_en during the load -> wr_err, no write.
- Abort: clr after 100 stream samples -> s_ready = 0, frame_ready = 0, no load_done, pixel (0,5) reads 0.
- Restart: load_start at sample 50 -> counters restart at (0,0,0); 3072 further samples are needed for load_done.
